rv32i_wb_arbiter: RTL and testbench
===================================

# rv32i_wb_arbiter

Writeback arbiter that consumes results from the RV32I execution functional units (adder, logic, shift, branch, load) over their registered valid/ready result handshake. Each cycle it selects one pending result with round-robin priority and broadcasts it on a single registered common data bus (CDB). The CDB carries the physical-register-file write and the ROB completion for that result. It sits between the functional-unit outputs and the physical register file, ROB, and reservation-station wakeup logic.

## Interface
Parameters:
- NUM_SRC, 4, number of functional-unit result sources (≥2)
- DATA_W, 32, result width
- TAG_W, PHYS_REG_FILE_IDX_BW (rv32i_pkg), physical destination tag width
- ROB_IDX_W, $clog2(ROB_DEPTH) (rv32i_pkg), ROB entry index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_src_vld  in  NUM_SRC  per-source result valid (FU o_vld)
- i_src_data  in  NUM_SRC*DATA_W  per-source result, source i at [i*DATA_W +: DATA_W]
- i_src_tag  in  NUM_SRC*TAG_W  per-source destination physical tag
- i_src_rob_idx  in  NUM_SRC*ROB_IDX_W  per-source ROB entry index
- o_src_rdy  out  NUM_SRC  per-source accept (drives FU i_rdy)
- o_cdb_vld  out  1  broadcast valid
- o_cdb_data  out  DATA_W  broadcast result
- o_cdb_tag  out  TAG_W  broadcast physical tag
- o_cdb_rob_idx  out  ROB_IDX_W  broadcast ROB index
- o_cdb_rf_wen  out  1  register file write enable = o_cdb_vld & (o_cdb_tag != 0)
- i_wb_rdy  in  1  downstream accepts current broadcast
- o_conflict_cnt  out  16  saturating count of cycles with ≥2 sources valid

## Operation
- Output stage ready: out_rdy = ~o_cdb_vld | i_wb_rdy.
- Grant: combinational. The granted source is the first i with i_src_vld[i], searching from rr_ptr upward modulo NUM_SRC. No grant when no source is valid.
- o_src_rdy[i] = (grant == i) & out_rdy. At most one bit is set. o_src_rdy depends combinationally on i_src_vld. No loop exists because FU valids are registered.
- Transfer: i_src_vld[g] & o_src_rdy[g]. On transfer, o_cdb_* load source g's data, tag, and rob_idx, and o_cdb_vld <= 1.
- If o_cdb_vld & i_wb_rdy and there is no transfer, o_cdb_vld <= 0.
- While o_cdb_vld & ~i_wb_rdy, all o_cdb_* hold stable and every o_src_rdy is 0.
- rr_ptr: on transfer from g, rr_ptr <= (g+1) mod NUM_SRC. Otherwise it is unchanged.
- Physical tag 0 is the hardwired zero register. The result is still broadcast (ROB completion), but o_cdb_rf_wen is 0.
- o_conflict_cnt: increments when popcount(i_src_vld) ≥ 2, regardless of stall. It saturates at 16'hFFFF.
- Sources are independent. A source with no grant keeps its valid asserted and its payload stable (FU contract). The arbiter never drops or duplicates a result.

## Timing
- Latency: 1 cycle. A transfer at edge N makes the result visible on o_cdb_* after edge N and held until accepted.
- Throughput: 1 result/cycle when i_wb_rdy = 1. Back-to-back transfers are allowed: when the output stage is accepted, a new transfer into it happens in the same cycle.
- Fairness: with all sources continuously valid and no stall, each source is granted exactly once per NUM_SRC cycles.
- Reset values: o_cdb_vld = 0, o_cdb_data = 0, o_cdb_tag = 0, o_cdb_rob_idx = 0, o_cdb_rf_wen = 0, o_conflict_cnt = 0, rr_ptr = 0.
- o_src_rdy is 0 during the reset cycle. Reset takes priority over any transfer in the same cycle.
- Reset mid-operation discards any pending broadcast. Source-side state is the FUs' responsibility; they reset on the same edge.
- Wrap-around: grant search and rr_ptr increment are modulo NUM_SRC. For example, rr_ptr = 3 with sources 0 and 3 valid grants 3, then 0.

## Test plan
- Single source: src1 valid with data 0x0000_0005, tag 7, rob 3, i_wb_rdy = 1. Expect o_src_rdy = 4'b0010 in the same cycle. Next cycle o_cdb_vld = 1, data 5, tag 7, rob 3, rf_wen = 1.
- All four sources held valid, no stall, from reset. Expect grants 0,1,2,3,0 on consecutive cycles and o_conflict_cnt counting one per cycle.
- Backpressure: broadcast pending, i_wb_rdy = 0 for 3 cycles with src2 valid. Expect o_cdb_* unchanged, o_src_rdy = 0. On the i_wb_rdy = 1 cycle, src2 is granted and appears on the next cycle.
- Wrap: rr_ptr = 3 (after a src2 transfer), sources 0 and 3 valid. Expect source 3 granted, then 0, and rr_ptr returning to 1.
- Tag zero: source result with tag 0, data 0xDEAD_BEEF. Expect o_cdb_vld = 1, rob index broadcast, o_cdb_rf_wen = 0.
- Reset mid-operation: rst asserted for one cycle while a broadcast is stalled. Expect o_cdb_vld = 0, counter = 0, rr_ptr = 0 next cycle, and normal resumption afterward.

Source files
------------

// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter: round-robin writeback arbiter driving a single registered CDB
module rv32i_wb_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           i_src_vld,
    input  logic [NUM_SRC*DATA_W-1:0]    i_src_data,
    input  logic [NUM_SRC*TAG_W-1:0]     i_src_tag,
    input  logic [NUM_SRC*ROB_IDX_W-1:0] i_src_rob_idx,
    output logic [NUM_SRC-1:0]           o_src_rdy,
    output logic                         o_cdb_vld,
    output logic [DATA_W-1:0]            o_cdb_data,
    output logic [TAG_W-1:0]             o_cdb_tag,
    output logic [ROB_IDX_W-1:0]         o_cdb_rob_idx,
    output logic                         o_cdb_rf_wen,
    input  logic                         i_wb_rdy,
    output logic [15:0]                  o_conflict_cnt
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, gnt;
    logic                 gnt_vld, out_rdy, xfer, conflict;
    logic                 cdb_vld_q, cdb_vld_d;
    logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
    logic [ROB_IDX_W-1:0] cdb_rob_q, cdb_rob_d;
    logic [15:0]          cnt_q, cnt_d;
    int                   idx, nvld;

    // Search downward in rr order so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        nvld    = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            idx = idx >= NUM_SRC ? idx - NUM_SRC : idx;
            if (i_src_vld[idx]) begin
                gnt     = PTR_W'(idx);
                gnt_vld = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) nvld += int'(i_src_vld[i]);
    end

    always_comb begin
        out_rdy    = ~cdb_vld_q | i_wb_rdy;
        xfer       = gnt_vld & out_rdy & ~rst;
        conflict   = nvld >= 2;
        o_src_rdy  = xfer ? NUM_SRC'(1) << gnt : '0;
        rr_ptr_d   = xfer ? (gnt == PTR_W'(NUM_SRC - 1) ? '0 : gnt + PTR_W'(1)) : rr_ptr_q;
        cdb_vld_d  = xfer | (cdb_vld_q & ~i_wb_rdy);
        cdb_data_d = xfer ? i_src_data[int'(gnt)*DATA_W +: DATA_W] : cdb_data_q;
        cdb_tag_d  = xfer ? i_src_tag[int'(gnt)*TAG_W +: TAG_W] : cdb_tag_q;
        cdb_rob_d  = xfer ? i_src_rob_idx[int'(gnt)*ROB_IDX_W +: ROB_IDX_W] : cdb_rob_q;
        cnt_d      = conflict && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cdb_vld_q  <= 1'b0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
            cdb_rob_q  <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_vld_q  <= cdb_vld_d;
            cdb_data_q <= cdb_data_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_rob_q  <= cdb_rob_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_cdb_vld      = cdb_vld_q;
    assign o_cdb_data     = cdb_data_q;
    assign o_cdb_tag      = cdb_tag_q;
    assign o_cdb_rob_idx  = cdb_rob_q;
    assign o_cdb_rf_wen   = cdb_vld_q & |cdb_tag_q;
    assign o_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter: directed self-checking bench for the writeback arbiter
module tb_rv32i_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_vld;
    logic [N*DW-1:0] src_data;
    logic [N*TW-1:0] src_tag;
    logic [N*RW-1:0] src_rob;
    logic [N-1:0]    src_rdy;
    logic            cdb_vld, cdb_rf_wen, wb_rdy;
    logic [DW-1:0]   cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic [RW-1:0]   cdb_rob;
    logic [15:0]     conflict_cnt;
    int              n_chk = 0, n_pass = 0;

    rv32i_wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .ROB_IDX_W(RW)) dut (
        .clk(clk), .rst(rst),
        .i_src_vld(src_vld), .i_src_data(src_data), .i_src_tag(src_tag), .i_src_rob_idx(src_rob),
        .o_src_rdy(src_rdy),
        .o_cdb_vld(cdb_vld), .o_cdb_data(cdb_data), .o_cdb_tag(cdb_tag), .o_cdb_rob_idx(cdb_rob),
        .o_cdb_rf_wen(cdb_rf_wen), .i_wb_rdy(wb_rdy), .o_conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [DW-1:0] d,
                         input logic [TW-1:0] t, input logic [RW-1:0] r);
        src_vld[i]          = v;
        src_data[i*DW +: DW] = d;
        src_tag[i*TW +: TW]  = t;
        src_rob[i*RW +: RW]  = r;
    endtask

    initial begin
        rst = 1'b1; wb_rdy = 1'b1;
        src_vld = '0; src_data = '0; src_tag = '0; src_rob = '0;
        step();
        drive(1, 1'b1, 32'h5, 6'd7, 5'd3);
        #1 check("rdy_in_reset", src_rdy, 4'b0000);
        step();
        rst = 1'b0;
        src_vld = '0;
        #1;
        check("rst_vld", cdb_vld, 0);
        check("rst_data", cdb_data, 0);
        check("rst_tag", cdb_tag, 0);
        check("rst_rob", cdb_rob, 0);
        check("rst_wen", cdb_rf_wen, 0);
        check("rst_cnt", conflict_cnt, 0);
        // single source
        drive(1, 1'b1, 32'h5, 6'd7, 5'd3);
        #1 check("single_rdy", src_rdy, 4'b0010);
        step();
        src_vld = '0;
        check("single_vld", cdb_vld, 1);
        check("single_data", cdb_data, 32'h5);
        check("single_tag", cdb_tag, 7);
        check("single_rob", cdb_rob, 3);
        check("single_wen", cdb_rf_wen, 1);
        step();
        check("drain_vld", cdb_vld, 0);
        // fairness from reset with all sources valid
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 32'h100 + i, TW'(i + 1), RW'(i));
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("fair_rdy%0d", c), src_rdy, 4'b0001 << (c % 4));
            step();
            check($sformatf("fair_data%0d", c), cdb_data, 32'h100 + (c % 4));
            check($sformatf("fair_cnt%0d", c), conflict_cnt, c + 1);
        end
        src_vld = '0;
        // backpressure with src2 pending; rr_ptr is 1
        wb_rdy = 1'b0;
        drive(2, 1'b1, 32'hAAAA, 6'd9, 5'd2);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("bp_rdy%0d", c), src_rdy, 0);
            check($sformatf("bp_data%0d", c), cdb_data, 32'h100);
            check($sformatf("bp_vld%0d", c), cdb_vld, 1);
            step();
        end
        wb_rdy = 1'b1;
        #1 check("bp_release_rdy", src_rdy, 4'b0100);
        step();
        src_vld = '0;
        check("bp_data", cdb_data, 32'hAAAA);
        check("bp_tag", cdb_tag, 9);
        // wrap: rr_ptr is 3
        drive(0, 1'b1, 32'h11, 6'd4, 5'd1);
        drive(3, 1'b1, 32'h33, 6'd5, 5'd6);
        #1 check("wrap_rdy3", src_rdy, 4'b1000);
        step();
        src_vld[3] = 1'b0;
        check("wrap_data3", cdb_data, 32'h33);
        #1 check("wrap_rdy0", src_rdy, 4'b0001);
        step();
        src_vld = '0;
        check("wrap_data0", cdb_data, 32'h11);
        check("wrap_rob0", cdb_rob, 1);
        src_vld = 4'b1111;
        #1 check("wrap_ptr1", src_rdy, 4'b0010);
        src_vld = '0;
        check("wrap_cnt", conflict_cnt, 6);
        // tag zero: still broadcast, no register write
        drive(1, 1'b1, 32'hDEADBEEF, 6'd0, 5'd13);
        step();
        src_vld = '0;
        check("tz_vld", cdb_vld, 1);
        check("tz_data", cdb_data, 32'hDEADBEEF);
        check("tz_rob", cdb_rob, 13);
        check("tz_wen", cdb_rf_wen, 0);
        // reset while a broadcast is stalled
        drive(2, 1'b1, 32'h77, 6'd3, 5'd4);
        step();
        src_vld = '0;
        check("mr_data", cdb_data, 32'h77);
        wb_rdy = 1'b0;
        drive(0, 1'b1, 32'hA0, 6'd10, 5'd7);
        drive(1, 1'b1, 32'hA1, 6'd11, 5'd8);
        step();
        check("mr_stall_cnt", conflict_cnt, 7);
        check("mr_stall_data", cdb_data, 32'h77);
        rst = 1'b1;
        #1 check("mr_rdy_in_reset", src_rdy, 0);
        step();
        rst = 1'b0;
        check("mr_vld", cdb_vld, 0);
        check("mr_cnt", conflict_cnt, 0);
        check("mr_cdb_data", cdb_data, 0);
        #1 check("mr_resume_rdy", src_rdy, 4'b0001);
        step();
        src_vld[0] = 1'b0;
        check("mr_resume_data", cdb_data, 32'hA0);
        check("mr_resume_cnt", conflict_cnt, 1);
        #1 check("mr_stalled_rdy", src_rdy, 0);
        wb_rdy = 1'b1;
        #1 check("mr_next_rdy", src_rdy, 4'b0010);
        step();
        src_vld = '0;
        check("mr_next_data", cdb_data, 32'hA1);
        check("mr_next_tag", cdb_tag, 11);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
